address_generator: RTL and testbench

ADDRESS_GENERATOR -- requirements
Module: address_generator

---
 rtl/address_generator.sv | 87 ++++++++
 tb/tb_address_generator.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/address_generator.sv
// rtl/address_generator.sv - burst address generator producing paired source/destination address streams
module address_generator #(
    parameter int ADDR_WIDTH = 16,
    parameter int BURST_LEN  = 4,
    parameter int ADDR_STEP  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] src_address_in_i,
    input  logic [ADDR_WIDTH-1:0] dst_address_in_i,
    output logic [ADDR_WIDTH-1:0] src_address_out_o,
    output logic [ADDR_WIDTH-1:0] dst_address_out_o,
    output logic                  addr_valid_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GEN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(ADDR_STEP);

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [ADDR_WIDTH-1:0] r_src;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic                  r_valid;
    logic                  r_done;

    // Addresses are only loaded in IDLE and otherwise advance or hold, so they
    // keep the final beat value once the burst completes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_src   <= '0;
            r_dst   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start_i) begin
                        r_state <= S_GEN;
                        r_src   <= src_address_in_i;
                        r_dst   <= dst_address_in_i;
                        r_valid <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                S_GEN: begin
                    if (r_cnt == LAST_BEAT) begin
                        r_state <= S_DONE;
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_src <= r_src + STEP;
                        r_dst <= r_dst + STEP;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign src_address_out_o = r_src;
    assign dst_address_out_o = r_dst;
    assign addr_valid_o      = r_valid;
    assign done_o            = r_done;
    assign busy_o            = (r_state != S_IDLE);

endmodule

// File: tb/tb_address_generator.sv
// tb/tb_address_generator.sv - scoreboard bench for address_generator with default parameters
module tb_address_generator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] src_in;
    logic [15:0] dst_in;
    logic [15:0] src_o;
    logic [15:0] dst_o;
    logic        valid_o;
    logic        busy_o;
    logic        done_o;

    typedef struct packed {
        logic [15:0] src;
        logic [15:0] dst;
    } beat_t;

    beat_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    address_generator dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .start_i           (start),
        .src_address_in_i  (src_in),
        .dst_address_in_i  (dst_in),
        .src_address_out_o (src_o),
        .dst_address_out_o (dst_o),
        .addr_valid_o      (valid_o),
        .busy_o            (busy_o),
        .done_o            (done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_burst(input logic [15:0] s, input logic [15:0] d);
        for (int i = 0; i < 4; i++) begin
            beat_t b;
            b.src = s + 16'(i);
            b.dst = d + 16'(i);
            exp_q.push_back(b);
        end
    endtask

    // Called at a negedge; start is seen by the next posedge and then dropped.
    task automatic start_pulse(input logic [15:0] s, input logic [15:0] d);
        start  = 1'b1;
        src_in = s;
        dst_in = d;
        push_burst(s, d);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic drain(input bit inject, input logic [15:0] hold_s, input logic [15:0] hold_d);
        int    beats = 0;
        int    cyc   = 0;
        bit    seen  = 1'b0;
        beat_t e;
        while (!seen && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (valid_o) begin
                beats++;
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 32'(beats), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_src", 32'(src_o), 32'(e.src));
                    chk("beat_dst", 32'(dst_o), 32'(e.dst));
                    chk("beat_busy", 32'(busy_o), 32'(1));
                end
            end
            if (done_o) begin
                seen = 1'b1;
                chk("done_valid_low", 32'(valid_o), 32'(0));
                chk("done_busy", 32'(busy_o), 32'(1));
            end
            if (inject && cyc == 2) begin
                start  = 1'b1;
                src_in = 16'h5555;
                dst_in = 16'h6666;
            end
            if (inject && cyc == 3) start = 1'b0;
        end
        chk("done_seen", 32'(seen), 32'(1));
        chk("beat_count", 32'(beats), 32'(4));
        chk("queue_empty", 32'(exp_q.size()), 32'(0));
        @(negedge clk);
        chk("done_one_cycle", 32'(done_o), 32'(0));
        chk("busy_after", 32'(busy_o), 32'(0));
        chk("valid_after", 32'(valid_o), 32'(0));
        chk("hold_src", 32'(src_o), 32'(hold_s));
        chk("hold_dst", 32'(dst_o), 32'(hold_d));
    endtask

    initial begin
        beat_t e;
        rst    = 1'b1;
        start  = 1'b0;
        src_in = 16'h0;
        dst_in = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_src", 32'(src_o), 32'(0));
        chk("rst_dst", 32'(dst_o), 32'(0));
        chk("rst_valid", 32'(valid_o), 32'(0));
        chk("rst_busy", 32'(busy_o), 32'(0));
        chk("rst_done", 32'(done_o), 32'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        start_pulse(16'h1111, 16'h2222);
        drain(1'b0, 16'h1114, 16'h2225);

        repeat (3) @(negedge clk);
        chk("idle_hold_src", 32'(src_o), 32'h1114);
        start_pulse(16'h3333, 16'h4444);
        drain(1'b0, 16'h3336, 16'h4447);

        @(negedge clk);
        start_pulse(16'hFFFE, 16'h0000);
        drain(1'b0, 16'h0001, 16'h0003);

        @(negedge clk);
        start_pulse(16'h1111, 16'h2222);
        drain(1'b1, 16'h1114, 16'h2225);
        repeat (3) @(negedge clk);
        chk("ignored_no_burst", 32'(busy_o), 32'(0));

        // Abort after the second beat; remaining expectations are discarded.
        @(negedge clk);
        start_pulse(16'hAAAA, 16'hBBBB);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            chk("abort_beat_src", 32'(src_o), 32'(e.src));
            chk("abort_beat_valid", 32'(valid_o), 32'(1));
        end
        exp_q.delete();
        rst = 1'b1;
        @(negedge clk);
        chk("abort_src", 32'(src_o), 32'(0));
        chk("abort_dst", 32'(dst_o), 32'(0));
        chk("abort_valid", 32'(valid_o), 32'(0));
        chk("abort_busy", 32'(busy_o), 32'(0));
        chk("abort_done", 32'(done_o), 32'(0));
        rst = 1'b0;
        start_pulse(16'h7777, 16'h8888);
        drain(1'b0, 16'h777A, 16'h888B);

        // Held start: 4 beats, one DONE, one IDLE, then the next burst.
        @(negedge clk);
        start  = 1'b1;
        src_in = 16'h1000;
        dst_in = 16'h2000;
        @(posedge clk);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("cont_valid", 32'(valid_o), 32'((k % 6) < 4));
            chk("cont_done", 32'(done_o), 32'((k % 6) == 4));
            if ((k % 6) < 4) begin
                chk("cont_src", 32'(src_o), 32'(16'h1000 + 16'(k % 6)));
                chk("cont_dst", 32'(dst_o), 32'(16'h2000 + 16'(k % 6)));
            end
        end
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("cont_end_busy", 32'(busy_o), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
